// File: rtl/uart_mmio_pkg.sv
// Shared register map, STATUS bit positions and offset decoder for the UART MMIO responder.
package uart_mmio_pkg;

  localparam int UART_TXDATA = 'h0;
  localparam int UART_RXDATA = 'h4;
  localparam int UART_STATUS = 'h8;

  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_COUNT_LSB = 8;

  // Returned for RXDATA loads when the RX path is compiled out: "no data".
  localparam logic [63:0] RX_NODATA = 64'hFF;

  typedef enum logic [1:0] {
    REG_TXDATA,
    REG_RXDATA,
    REG_STATUS,
    REG_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_offset(input logic [31:0] offset);
    case (offset)
      32'(UART_TXDATA): return REG_TXDATA;
      32'(UART_RXDATA): return REG_RXDATA;
      32'(UART_STATUS): return REG_STATUS;
      default:          return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_mmio_if.sv
// Data-memory style request/response port between the core (master) and the UART responder (slave).
interface uart_mmio_if #(
  parameter int ADDR_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic              resp_valid;
  logic [63:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmit path; head byte is readable in the same cycle it pops.
module uart_tx_fifo #(
  parameter int TX_DEPTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push,
  input  logic [7:0]                push_data,
  input  logic                      pop,
  output logic [7:0]                pop_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(TX_DEPTH):0] count
);
  localparam int PTR_W = $clog2(TX_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       mem [TX_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count_reg == CNT_W'(TX_DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  // Asynchronous read: the byte must leave on the same cycle as its pop.
  assign pop_data = mem[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART responder: TXDATA stores feed a paced TX FIFO, RXDATA loads fetch a byte
// from the simulator, STATUS reports FIFO state. Define UART_MMIO_RX_EN to build the RX path.
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter int TX_DEPTH = 8,
  parameter int TX_GAP   = 0,
  parameter int ADDR_W   = 4
) (
  input  logic        clock,
  input  logic        reset,
  uart_mmio_if.slave  bus,
  output logic        io_uart_out_valid,
  output logic [7:0]  io_uart_out_ch,
  output logic        io_uart_in_valid,
  input  logic [7:0]  io_uart_in_ch
);
  localparam int CNT_W = $clog2(TX_DEPTH) + 1;
  localparam int GAP_W = (TX_GAP > 0) ? $clog2(TX_GAP + 1) : 1;

  logic [ADDR_W-1:0] addr;
  reg_sel_e          sel;
  logic              accept;
  logic              tx_push;
  logic              tx_pop;
  logic              tx_full;
  logic              tx_empty;
  logic [CNT_W-1:0]  tx_count;
  logic [7:0]        tx_head;
  logic [GAP_W-1:0]  gap_cnt_reg;
  logic [GAP_W-1:0]  gap_cnt_next;
  logic              resp_valid_reg;
  logic [63:0]       resp_rdata_reg;
  logic [63:0]       rdata_next;
  logic              resp_err_reg;
  logic [63:0]       status_word;
  logic              wdata_unused;

  assign addr         = bus.req_addr;
  assign sel          = decode_offset(32'(addr));
  assign wdata_unused = ^bus.req_wdata[63:8];

  // Stall only TXDATA stores against the registered full flag; a same-cycle pop does not help.
  assign bus.req_ready = !reset && !(bus.req_wen && (sel == REG_TXDATA) && tx_full);
  assign accept        = bus.req_valid && bus.req_ready;
  assign tx_push       = accept && bus.req_wen && (sel == REG_TXDATA);
  assign tx_pop        = !reset && !tx_empty && (gap_cnt_reg == '0);

  assign io_uart_out_valid = tx_pop;
  assign io_uart_out_ch    = tx_pop ? tx_head : 8'h00;

  uart_tx_fifo #(
    .TX_DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (tx_push),
    .push_data (bus.req_wdata[7:0]),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  always_comb begin
    gap_cnt_next = gap_cnt_reg;
    if (tx_pop) begin
      gap_cnt_next = GAP_W'(TX_GAP);
    end else if (gap_cnt_reg != '0) begin
      gap_cnt_next = gap_cnt_reg - GAP_W'(1);
    end
  end

  assign status_word[STATUS_FULL_BIT]  = tx_full;
  assign status_word[STATUS_EMPTY_BIT] = tx_empty;
  assign status_word[7:2]              = '0;
  assign status_word[63:16]            = '0;

  for (genvar gi = 0; gi < 8; gi++) begin : g_status_cnt
    if (gi < CNT_W) begin : g_bit
      assign status_word[STATUS_COUNT_LSB + gi] = tx_count[gi];
    end else begin : g_zero
      assign status_word[STATUS_COUNT_LSB + gi] = 1'b0;
    end
  end

`ifdef UART_MMIO_RX_EN
  assign io_uart_in_valid = accept && !bus.req_wen && (sel == REG_RXDATA);
`else
  logic rx_unused;
  assign io_uart_in_valid = 1'b0;
  assign rx_unused        = ^io_uart_in_ch;
`endif

  always_comb begin
    rdata_next = '0;
    if (!bus.req_wen) begin
      case (sel)
        REG_STATUS: rdata_next = status_word;
`ifdef UART_MMIO_RX_EN
        REG_RXDATA: rdata_next = {56'b0, io_uart_in_ch};
`else
        REG_RXDATA: rdata_next = RX_NODATA;
`endif
        default:    rdata_next = '0;
      endcase
    end
  end

  // The response register doubles as the RX byte capture at the acceptance edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid_reg <= 1'b0;
      resp_rdata_reg <= '0;
      resp_err_reg   <= 1'b0;
      gap_cnt_reg    <= '0;
    end else begin
      resp_valid_reg <= accept;
      resp_rdata_reg <= accept ? rdata_next : '0;
      resp_err_reg   <= accept && (sel == REG_NONE);
      gap_cnt_reg    <= gap_cnt_next;
    end
  end

  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_rdata = resp_rdata_reg;
  assign bus.resp_err   = resp_err_reg;

endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio: three instances (TX_GAP 0, 3, 40) sharing clock, reset and RX byte.
module tb_uart_mmio;

`ifdef UART_MMIO_RX_EN
  localparam logic        RX_ON  = 1'b1;
  localparam logic [63:0] EXP_5A = 64'h5A;
`else
  localparam logic        RX_ON  = 1'b0;
  localparam logic [63:0] EXP_5A = 64'hFF;
`endif

  logic       clock;
  logic       reset;
  logic [7:0] in_ch;
  logic       out_v_a, out_v_b, out_v_c;
  logic [7:0] out_ch_a, out_ch_b, out_ch_c;
  logic       in_v_a, in_v_b, in_v_c;
  int         cyc;
  int         checks;
  int         failures;

  logic [7:0] qa_ch[$], qb_ch[$], qc_ch[$];
  int         qa_cyc[$], qb_cyc[$], qc_cyc[$];

  uart_mmio_if #(.ADDR_W(4)) bus_a ();
  uart_mmio_if #(.ADDR_W(4)) bus_b ();
  uart_mmio_if #(.ADDR_W(4)) bus_c ();

  uart_mmio #(.TX_DEPTH(8), .TX_GAP(0), .ADDR_W(4)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a),
    .io_uart_out_valid(out_v_a), .io_uart_out_ch(out_ch_a),
    .io_uart_in_valid(in_v_a), .io_uart_in_ch(in_ch)
  );
  uart_mmio #(.TX_DEPTH(8), .TX_GAP(3), .ADDR_W(4)) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b),
    .io_uart_out_valid(out_v_b), .io_uart_out_ch(out_ch_b),
    .io_uart_in_valid(in_v_b), .io_uart_in_ch(in_ch)
  );
  uart_mmio #(.TX_DEPTH(8), .TX_GAP(40), .ADDR_W(4)) dut_c (
    .clock(clock), .reset(reset), .bus(bus_c),
    .io_uart_out_valid(out_v_c), .io_uart_out_ch(out_ch_c),
    .io_uart_in_valid(in_v_c), .io_uart_in_ch(in_ch)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Record every transmitted byte with the cycle it appeared in.
  always @(negedge clock) begin
    if (out_v_a) begin qa_ch.push_back(out_ch_a); qa_cyc.push_back(cyc); end
    if (out_v_b) begin qb_ch.push_back(out_ch_b); qb_cyc.push_back(cyc); end
    if (out_v_c) begin qc_ch.push_back(out_ch_c); qc_cyc.push_back(cyc); end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic w, input logic [3:0] a,
                       input logic [63:0] wd);
    case (d)
      0: begin bus_a.req_valid = v; bus_a.req_wen = w; bus_a.req_addr = a; bus_a.req_wdata = wd; end
      1: begin bus_b.req_valid = v; bus_b.req_wen = w; bus_b.req_addr = a; bus_b.req_wdata = wd; end
      default: begin bus_c.req_valid = v; bus_c.req_wen = w; bus_c.req_addr = a; bus_c.req_wdata = wd; end
    endcase
  endtask

  function automatic logic get_ready(input int d);
    case (d)
      0: return bus_a.req_ready;
      1: return bus_b.req_ready;
      default: return bus_c.req_ready;
    endcase
  endfunction

  function automatic logic get_resp_valid(input int d);
    case (d)
      0: return bus_a.resp_valid;
      1: return bus_b.resp_valid;
      default: return bus_c.resp_valid;
    endcase
  endfunction

  function automatic logic [63:0] get_rdata(input int d);
    case (d)
      0: return bus_a.resp_rdata;
      1: return bus_b.resp_rdata;
      default: return bus_c.resp_rdata;
    endcase
  endfunction

  function automatic logic get_err(input int d);
    case (d)
      0: return bus_a.resp_err;
      1: return bus_b.resp_err;
      default: return bus_c.resp_err;
    endcase
  endfunction

  function automatic logic get_in_valid(input int d);
    case (d)
      0: return in_v_a;
      1: return in_v_b;
      default: return in_v_c;
    endcase
  endfunction

  // One request: waits (bounded) for ready, returns in the response cycle with the response.
  task automatic issue(input int d, input logic w, input logic [3:0] a, input logic [63:0] wd,
                       output logic [63:0] rd, output logic er, output logic iv,
                       output int acc, output int stall);
    drive(d, 1'b1, w, a, wd);
    stall = 0;
    #1;
    while (!get_ready(d) && stall < 200) begin
      @(posedge clock); #2;
      stall++;
    end
    check("req_ready", get_ready(d), 1);
    iv  = get_in_valid(d);
    acc = cyc;
    @(posedge clock); #1;
    drive(d, 1'b0, 1'b0, 4'h0, 64'h0);
    in_ch = 8'h33;
    #1;
    check("resp_valid", get_resp_valid(d), 1);
    rd = get_rdata(d);
    er = get_err(d);
    $display("txn dut=%0d wen=%0b addr=%0h wdata=%0h rdata=%0h err=%0b in_valid=%0b cyc=%0d",
             d, w, a, wd, rd, er, iv, acc);
  endtask

  initial begin
    logic [63:0] rd;
    logic        er, iv;
    int          acc, acc_b, stall, n;

    checks = 0;
    failures = 0;
    reset = 1'b1;
    in_ch = 8'h00;
    drive(0, 1'b0, 1'b0, 4'h0, 64'h0);
    drive(1, 1'b0, 1'b0, 4'h0, 64'h0);
    drive(2, 1'b0, 1'b0, 4'h0, 64'h0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("rst_resp_valid", bus_a.resp_valid, 0);
    check("rst_resp_rdata", bus_a.resp_rdata, 0);
    check("rst_resp_err", bus_a.resp_err, 0);
    check("rst_out_valid", out_v_a, 0);
    check("rst_in_valid", in_v_a, 0);
    check("rst_out_valid_c", out_v_c, 0);

    // Test 1: single TXDATA store, TX_GAP=0
    issue(0, 1'b1, 4'h0, 64'h41, rd, er, iv, acc, stall);
    check("t1_store_rdata", rd, 0);
    check("t1_store_err", er, 0);
    @(posedge clock); #2;
    check("t1_resp_one_cycle", bus_a.resp_valid, 0);
    repeat (2) @(posedge clock);
    #2;
    check("t1_npulse", qa_ch.size(), 1);
    check("t1_ch", qa_ch[0], 8'h41);
    check("t1_latency_ok", (qa_cyc[0] - acc >= 1) && (qa_cyc[0] - acc <= 2), 1);
    issue(0, 1'b0, 4'h8, 64'h0, rd, er, iv, acc, stall);
    check("t1_status", rd, 64'h2);

    // Test 4: RXDATA loads
    in_ch = 8'h5A;
    issue(0, 1'b0, 4'h4, 64'h0, rd, er, iv, acc, stall);
    check("t4_in_valid", iv, RX_ON);
    check("t4_rdata_5a", rd, EXP_5A);
    check("t4_err", er, 0);
    @(posedge clock); #2;
    check("t4_in_valid_after", in_v_a, 0);
    in_ch = 8'hFF;
    issue(0, 1'b0, 4'h4, 64'h0, rd, er, iv, acc, stall);
    check("t4_rdata_ff", rd, 64'hFF);

    // Test 5: unmapped offset, RXDATA store, TXDATA load
    issue(0, 1'b0, 4'hC, 64'h0, rd, er, iv, acc, stall);
    check("t5_load_err", er, 1);
    check("t5_load_rdata", rd, 0);
    issue(0, 1'b1, 4'hC, 64'h77, rd, er, iv, acc, stall);
    check("t5_store_err", er, 1);
    issue(0, 1'b1, 4'h4, 64'h55, rd, er, iv, acc, stall);
    check("t5_rx_store_err", er, 0);
    check("t5_rx_store_in_valid", iv, 0);
    issue(0, 1'b0, 4'h0, 64'h0, rd, er, iv, acc, stall);
    check("t5_tx_load_rdata", rd, 0);
    check("t5_tx_load_err", er, 0);
    repeat (3) @(posedge clock);
    #2;
    check("t5_no_output", qa_ch.size(), 1);
    issue(0, 1'b0, 4'h8, 64'h0, rd, er, iv, acc, stall);
    check("t5_status", rd, 64'h2);

    // Test 2: TX_GAP=3, back-to-back 'a','b','c'
    drive(1, 1'b1, 1'b1, 4'h0, 64'h61);
    #1;
    check("t2_ready", bus_b.req_ready, 1);
    acc_b = cyc;
    @(posedge clock); #1;
    drive(1, 1'b1, 1'b1, 4'h0, 64'h62);
    #1;
    check("t2_resp_a", bus_b.resp_valid, 1);
    @(posedge clock); #1;
    drive(1, 1'b1, 1'b1, 4'h0, 64'h63);
    #1;
    check("t2_resp_b", bus_b.resp_valid, 1);
    @(posedge clock); #1;
    drive(1, 1'b0, 1'b0, 4'h0, 64'h0);
    #1;
    check("t2_resp_c", bus_b.resp_valid, 1);
    repeat (12) @(posedge clock);
    #2;
    check("t2_npulse", qb_ch.size(), 3);
    check("t2_ch0", qb_ch[0], 8'h61);
    check("t2_ch1", qb_ch[1], 8'h62);
    check("t2_ch2", qb_ch[2], 8'h63);
    check("t2_first_lat_ok", (qb_cyc[0] - acc_b >= 1) && (qb_cyc[0] - acc_b <= 2), 1);
    check("t2_gap01", qb_cyc[1] - qb_cyc[0], 4);
    check("t2_gap12", qb_cyc[2] - qb_cyc[1], 4);
    for (int i = 0; i < 3; i++) $display("txn dut=1 out ch=%0h cyc=%0d", qb_ch[i], qb_cyc[i]);

    // Test 3: TX_GAP=40 holds the drain off; fill 8, then a 9th store stalls
    issue(2, 1'b1, 4'h0, 64'h7A, rd, er, iv, acc, stall);
    for (int i = 0; i < 8; i++) begin
      issue(2, 1'b1, 4'h0, 64'(8'h30 + i), rd, er, iv, acc, stall);
    end
    issue(2, 1'b0, 4'h8, 64'h0, rd, er, iv, acc, stall);
    check("t3_status_full", rd, 64'h0801);
    issue(2, 1'b1, 4'h0, 64'h38, rd, er, iv, acc, stall);
    check("t3_stalled", stall > 0, 1);
    check("t3_pops_before_accept", qc_ch.size(), 2);
    check("t3_unstall_after_pop", acc, qc_cyc[1] + 1);
    n = 0;
    while (qc_ch.size() < 10 && n < 600) begin
      @(posedge clock); #1;
      n++;
    end
    check("t3_drained", qc_ch.size(), 10);
    for (int i = 0; i < 10; i++) begin
      check("t3_order", qc_ch[i], (i == 0) ? 8'h7A : 8'(8'h30 + i - 1));
    end

    // Test 6: queue 5 bytes during the gap, then reset
    for (int i = 0; i < 5; i++) begin
      issue(2, 1'b1, 4'h0, 64'(8'h50 + i), rd, er, iv, acc, stall);
    end
    issue(2, 1'b0, 4'h8, 64'h0, rd, er, iv, acc, stall);
    check("t6_status_5", rd, 64'h0500);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    #1;
    check("t6_out_valid", out_v_c, 0);
    issue(2, 1'b0, 4'h8, 64'h0, rd, er, iv, acc, stall);
    check("t6_status_empty", rd, 64'h2);
    repeat (60) @(posedge clock);
    #1;
    check("t6_no_output", qc_ch.size(), 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
